// File: rtl/branch_stall_ctrl.sv
// ---------------------------------------------------------------------------
// branch_stall_ctrl
//
// Front-end sequencer for the 5-stage MIPS core. It runs beside the ID-stage
// branch comparator and decides each cycle whether the front end advances,
// stalls (bubble into EX), flushes (squash IF/ID and redirect the PC) or
// freezes on request from the memory side. It also keeps two saturating
// performance counters: cycles spent bubbling and slots flushed.
//
// Ports
//   clk, rst_n          pipeline clock, asynchronous active-low reset
//   Branch, bne, Jump   ID-stage instruction class (beq / bne / j,jal)
//   uses_rs, uses_rt    ID instruction reads rs / rt
//   rs_id, rt_id        ID source register numbers
//   WriteReg_ex, RegWrite_ex, MemRead_ex   EX-stage destination and control
//   WriteReg_mem, MemRead_mem              MEM-stage destination and load flag
//   cmp_eq              forwarded ID comparator result (rs value == rt value)
//   freeze_req          level freeze request, held until freeze_ack is seen
//   cnt_clr             synchronous clear of both counters
//   PCWrite, IFIDWrite  PC and IF/ID update enables
//   IDEXBubble          zero the ID/EX control fields this cycle
//   IFFlush, CHmux      squash IF/ID, select branch/jump target into PC
//   pipe_hold           hold every pipeline register (freeze only)
//   freeze_ack          high while the FREEZE state is occupied
//   stall_cycles, flush_count  saturating performance counters
// ---------------------------------------------------------------------------
module branch_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Branch,
  input  logic             bne,
  input  logic             Jump,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic [4:0]       WriteReg_ex,
  input  logic             RegWrite_ex,
  input  logic             MemRead_ex,
  input  logic [4:0]       WriteReg_mem,
  input  logic             MemRead_mem,
  input  logic             cmp_eq,
  input  logic             freeze_req,
  input  logic             cnt_clr,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXBubble,
  output logic             IFFlush,
  output logic             CHmux,
  output logic             pipe_hold,
  output logic             freeze_ack,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t state, state_next;
  logic [1:0] rem, rem_next;

  // Hazard detection terms
  logic br;
  logic reads_rs, reads_rt;
  logic m_ex, m_mem;
  logic h2, h1;
  logic taken;

  // Ungated decision outputs
  logic pc_write_c, ifid_write_c, bubble_c, flush_c, chmux_c, hold_c;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Hazard classification. A branch compares both operands in ID, so it reads
  // rs and rt regardless of what the decoder says. Register 0 never matches
  // because $zero is never really written.
  always_comb begin
    br       = Branch | bne;
    reads_rs = uses_rs | br;
    reads_rt = uses_rt | br;

    m_ex  = (WriteReg_ex != 5'd0) &&
            ((reads_rs && (WriteReg_ex == rs_id)) ||
             (reads_rt && (WriteReg_ex == rt_id)));
    m_mem = (WriteReg_mem != 5'd0) &&
            ((reads_rs && (WriteReg_mem == rs_id)) ||
             (reads_rt && (WriteReg_mem == rt_id)));

    // A load feeding a branch needs two bubbles: the data is only available
    // for forwarding into the ID comparator after the load leaves MEM.
    h2 = br & MemRead_ex & m_ex;

    // One bubble: ALU result in EX feeding a branch, load in MEM feeding a
    // branch, or the classic load-use for an ordinary instruction.
    h1 = (br & RegWrite_ex & ~MemRead_ex & m_ex) |
         (br & MemRead_mem & m_mem) |
         (~br & MemRead_ex & m_ex);

    taken = (Branch & cmp_eq) | (bne & ~cmp_eq);
  end

  // Next-state and decision logic. H1 deliberately stays in RUN: the same
  // instruction is re-examined next cycle with the producer one stage further
  // along, which either clears the hazard or turns it into a smaller one.
  // A taken branch keeps PCWrite/IFIDWrite high so the target is actually
  // loaded while the wrong-path fetch is squashed, exactly like a jump.
  always_comb begin
    state_next   = state;
    rem_next     = rem;
    pc_write_c   = 1'b0;
    ifid_write_c = 1'b0;
    bubble_c     = 1'b0;
    flush_c      = 1'b0;
    chmux_c      = 1'b0;
    hold_c       = 1'b0;

    unique case (state)
      RUN: begin
        if (freeze_req) begin
          hold_c     = 1'b1;
          state_next = FREEZE;
        end else if (h2) begin
          bubble_c   = 1'b1;
          rem_next   = 2'd1;
          state_next = STALL;
        end else if (h1) begin
          bubble_c = 1'b1;
        end else if (Jump || taken) begin
          pc_write_c   = 1'b1;
          ifid_write_c = 1'b1;
          flush_c      = 1'b1;
          chmux_c      = 1'b1;
        end else begin
          pc_write_c   = 1'b1;
          ifid_write_c = 1'b1;
        end
      end

      // Inputs, including freeze_req, are not looked at here; a pending
      // freeze is picked up by the first RUN cycle afterwards.
      STALL: begin
        bubble_c = 1'b1;
        rem_next = (rem != 2'd0) ? (rem - 2'd1) : 2'd0;
        if (rem_next == 2'd0) begin
          state_next = RUN;
        end
      end

      FREEZE: begin
        hold_c = 1'b1;
        if (!freeze_req) begin
          state_next = RUN;
        end
      end

      default: begin
        state_next = RUN;
        rem_next   = 2'd0;
      end
    endcase
  end

  // While reset is asserted every decision output is forced low, including
  // PCWrite, so nothing in the front end moves.
  assign PCWrite    = rst_n & pc_write_c;
  assign IFIDWrite  = rst_n & ifid_write_c;
  assign IDEXBubble = rst_n & bubble_c;
  assign IFFlush    = rst_n & flush_c;
  assign CHmux      = rst_n & chmux_c;
  assign pipe_hold  = rst_n & hold_c;

  // freeze_ack is simply the registered state, so it rises the cycle after the
  // request is accepted and falls the cycle after the request drops.
  assign freeze_ack = (state == FREEZE);

  // State and remaining-stall register; reset aborts any stall or freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rem   <= 2'd0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  // Performance counters: clear beats increment, and both stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (cnt_clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (IDEXBubble && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (IFFlush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_stall_ctrl
//
// Directed bench for branch_stall_ctrl built with 4-bit counters so counter
// saturation is reachable quickly. Inputs change on the falling edge; the
// combinational decision outputs and counters are sampled 1 time unit later.
// Decision outputs are compared as one packed vector:
//   {PCWrite, IFIDWrite, IDEXBubble, IFFlush, CHmux, pipe_hold, freeze_ack}
// ---------------------------------------------------------------------------
module tb_branch_stall_ctrl;

  localparam int CNT_W = 4;

  localparam logic [6:0] ADV  = 7'b1100000;
  localparam logic [6:0] STL  = 7'b0010000;
  localparam logic [6:0] TKN  = 7'b1101100;
  localparam logic [6:0] FRZ  = 7'b0000010;
  localparam logic [6:0] FRZA = 7'b0000011;
  localparam logic [6:0] ZERO = 7'b0000000;

  logic clk = 1'b0;
  logic rst_n;
  logic Branch, bne, Jump, uses_rs, uses_rt;
  logic [4:0] rs_id, rt_id, WriteReg_ex, WriteReg_mem;
  logic RegWrite_ex, MemRead_ex, MemRead_mem, cmp_eq, freeze_req, cnt_clr;
  logic PCWrite, IFIDWrite, IDEXBubble, IFFlush, CHmux, pipe_hold, freeze_ack;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [6:0] dec;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign dec = {PCWrite, IFIDWrite, IDEXBubble, IFFlush, CHmux, pipe_hold, freeze_ack};

  branch_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Branch(Branch), .bne(bne), .Jump(Jump),
    .uses_rs(uses_rs), .uses_rt(uses_rt),
    .rs_id(rs_id), .rt_id(rt_id),
    .WriteReg_ex(WriteReg_ex), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .WriteReg_mem(WriteReg_mem), .MemRead_mem(MemRead_mem),
    .cmp_eq(cmp_eq), .freeze_req(freeze_req), .cnt_clr(cnt_clr),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
    .IFFlush(IFFlush), .CHmux(CHmux), .pipe_hold(pipe_hold),
    .freeze_ack(freeze_ack),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of ID/EX/MEM context on the falling edge, then
  // let the combinational outputs settle before the caller samples them.
  task automatic applyStimulus(
    input logic br, input logic bn, input logic jmp,
    input logic urs, input logic urt,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic mrex, input logic rwex, input logic [4:0] wex,
    input logic mrmem, input logic [4:0] wmem,
    input logic cmp, input logic frz);
    @(negedge clk);
    Branch       = br;
    bne          = bn;
    Jump         = jmp;
    uses_rs      = urs;
    uses_rt      = urt;
    rs_id        = rs;
    rt_id        = rt;
    MemRead_ex   = mrex;
    RegWrite_ex  = rwex;
    WriteReg_ex  = wex;
    MemRead_mem  = mrmem;
    WriteReg_mem = wmem;
    cmp_eq       = cmp;
    freeze_req   = frz;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    Branch = 1'b0; bne = 1'b0; Jump = 1'b1; uses_rs = 1'b0; uses_rt = 1'b0;
    rs_id = 5'd0; rt_id = 5'd0; WriteReg_ex = 5'd0; RegWrite_ex = 1'b0;
    MemRead_ex = 1'b0; WriteReg_mem = 5'd0; MemRead_mem = 1'b0;
    cmp_eq = 1'b0; freeze_req = 1'b0;
    #2;
    // Reset forces every decision output low even with Jump asserted
    checkOutput("reset_dec", 32'(dec), 32'(ZERO));
    checkOutput("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    checkOutput("reset_flush_cnt", 32'(flush_count), 32'd0);
    Jump = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0,0,0, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,0);
    checkOutput("idle_adv", 32'(dec), 32'(ADV));

    // Load-use: lw $t0 in EX, add reads rs=8
    applyStimulus(0,0,0, 1,0, 5'd8,5'd5, 1,1,5'd8, 0,5'd0, 0,0);
    checkOutput("loaduse_stall", 32'(dec), 32'(STL));
    applyStimulus(0,0,0, 1,0, 5'd8,5'd5, 0,0,5'd0, 1,5'd8, 0,0);
    checkOutput("loaduse_adv", 32'(dec), 32'(ADV));
    checkOutput("loaduse_cnt", 32'(stall_cycles), 32'd1);
    // rt matches but the instruction does not read rt
    applyStimulus(0,0,0, 1,0, 5'd3,5'd8, 1,1,5'd8, 0,5'd0, 0,0);
    checkOutput("unused_rt_adv", 32'(dec), 32'(ADV));
    cnt_clr = 1'b1;

    // Load-to-branch: two bubbles even though the compare says taken
    applyStimulus(1,0,0, 1,1, 5'd9,5'd3, 1,1,5'd9, 0,5'd0, 1,0);
    cnt_clr = 1'b0;
    checkOutput("ldbr_stall1", 32'(dec), 32'(STL));
    checkOutput("ldbr_cnt_clr", 32'(stall_cycles), 32'd0);
    applyStimulus(1,0,0, 1,1, 5'd9,5'd3, 1,1,5'd9, 0,5'd0, 1,0);
    checkOutput("ldbr_stall2", 32'(dec), 32'(STL));
    applyStimulus(1,0,0, 1,1, 5'd9,5'd3, 0,0,5'd0, 0,5'd0, 1,0);
    checkOutput("ldbr_taken", 32'(dec), 32'(TKN));
    checkOutput("ldbr_stall_cnt", 32'(stall_cycles), 32'd2);
    applyStimulus(0,0,0, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,0);
    checkOutput("ldbr_after", 32'(dec), 32'(ADV));
    checkOutput("ldbr_flush_cnt", 32'(flush_count), 32'd1);

    // ALU result feeding bne via rt: one bubble, then not taken
    applyStimulus(0,1,0, 1,1, 5'd4,5'd10, 0,1,5'd10, 0,5'd0, 0,0);
    checkOutput("alubne_stall", 32'(dec), 32'(STL));
    applyStimulus(0,1,0, 1,1, 5'd4,5'd10, 0,0,5'd0, 0,5'd10, 1,0);
    checkOutput("alubne_nottaken", 32'(dec), 32'(ADV));
    // $zero never creates a hazard
    applyStimulus(1,0,0, 1,1, 5'd0,5'd0, 1,1,5'd0, 1,5'd0, 0,0);
    checkOutput("zero_reg_adv", 32'(dec), 32'(ADV));
    // Load in MEM feeding a branch: one bubble, then taken bne
    applyStimulus(0,1,0, 1,1, 5'd4,5'd11, 0,0,5'd0, 1,5'd11, 1,0);
    checkOutput("ldmem_br_stall", 32'(dec), 32'(STL));
    applyStimulus(0,1,0, 1,1, 5'd4,5'd11, 0,0,5'd0, 0,5'd0, 0,0);
    checkOutput("bne_taken", 32'(dec), 32'(TKN));

    // Freeze requested during STALL is only taken after STALL ends
    applyStimulus(1,0,0, 1,1, 5'd9,5'd3, 1,1,5'd9, 0,5'd0, 0,0);
    checkOutput("frz_h2", 32'(dec), 32'(STL));
    applyStimulus(1,0,0, 1,1, 5'd9,5'd3, 1,1,5'd9, 0,5'd0, 0,1);
    checkOutput("frz_in_stall", 32'(dec), 32'(STL));
    applyStimulus(0,0,0, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,1);
    checkOutput("frz_accept", 32'(dec), 32'(FRZ));
    applyStimulus(0,0,0, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,1);
    checkOutput("frz_hold1", 32'(dec), 32'(FRZA));
    applyStimulus(0,0,1, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,1);
    checkOutput("frz_hold2", 32'(dec), 32'(FRZA));
    applyStimulus(0,0,0, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,0);
    checkOutput("frz_hold3", 32'(dec), 32'(FRZA));
    applyStimulus(0,0,0, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,0);
    checkOutput("frz_release", 32'(dec), 32'(ADV));
    checkOutput("frz_stall_cnt", 32'(stall_cycles), 32'd6);
    checkOutput("frz_flush_cnt", 32'(flush_count), 32'd2);

    // Jump, then reset asserted in the middle of an H2 stall
    applyStimulus(0,0,1, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,0);
    checkOutput("jump", 32'(dec), 32'(TKN));
    applyStimulus(1,0,0, 1,1, 5'd9,5'd3, 1,1,5'd9, 0,5'd0, 0,0);
    checkOutput("rst_h2", 32'(dec), 32'(STL));
    applyStimulus(1,0,0, 1,1, 5'd9,5'd3, 1,1,5'd9, 0,5'd0, 0,0);
    checkOutput("rst_in_stall", 32'(dec), 32'(STL));
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_dec", 32'(dec), 32'(ZERO));
    checkOutput("rst_mid_stall_cnt", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(0,0,0, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,0);
    checkOutput("post_rst_run", 32'(dec), 32'(ADV));
    checkOutput("post_rst_flush_cnt", 32'(flush_count), 32'd0);

    // Saturation of the 4-bit stall counter, then clear beating increment
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0,0,0, 1,0, 5'd8,5'd5, 1,1,5'd8, 0,5'd0, 0,0);
    end
    applyStimulus(0,0,0, 1,0, 5'd8,5'd5, 1,1,5'd8, 0,5'd0, 0,0);
    checkOutput("sat_reach", 32'(stall_cycles), 32'd15);
    applyStimulus(0,0,0, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,0);
    checkOutput("sat_hold", 32'(stall_cycles), 32'd15);
    checkOutput("sat_flush_cnt", 32'(flush_count), 32'd0);
    applyStimulus(0,0,0, 1,0, 5'd8,5'd5, 1,1,5'd8, 0,5'd0, 0,0);
    cnt_clr = 1'b1;
    applyStimulus(0,0,0, 0,0, 5'd0,5'd0, 0,0,5'd0, 0,5'd0, 0,0);
    cnt_clr = 1'b0;
    checkOutput("clr_priority", 32'(stall_cycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
